// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with press/release debounce.
// Drives one row low at a time, samples active-low columns through a
// 2-flop synchronizer, then debounces the first key found and tracks it
// until its release is debounced. Optional macro KEYPAD_HEX_MAP_EN maps
// the raw code of a 4x4 pad to the lab keypad legend.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_SCAN    | drive row r for SCAN_DIV cycles, sample on last cycle
// ST_PRESS   | row/col frozen, count consecutive low cycles of col c
// ST_HELD    | key accepted, key_held high, watch col c for release
// ST_RELEASE | count consecutive high cycles of col c
module keypad_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CODE_W          = $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COLS-1:0]   col_n,
    output logic [ROWS-1:0]   row_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held
);

    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);
    localparam int DV_W = $clog2(SCAN_DIV);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DV_W-1:0] DWELL_LOAD = DV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] PRESS_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
    // The HELD cycle that first sees the column high counts as one.
    localparam logic [DB_W-1:0] REL_LOAD   = DB_W'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_PRESS,
        ST_HELD,
        ST_RELEASE
    } state_t;

    state_t            state, state_nx;
    logic [DV_W-1:0]   dwell, dwell_nx;
    logic [DB_W-1:0]   db_cnt, db_nx;
    logic [RW-1:0]     r, r_nx, r_inc;
    logic [CW-1:0]     c, c_nx, low_idx;
    logic [COLS-1:0]   sync1, sync2;
    logic [CODE_W-1:0] code_nx, raw_code, mapped_code;
    logic              valid_nx, any_low, col_sel;

    assign r_inc    = (r == RW'(ROWS - 1)) ? '0 : r + RW'(1);
    assign col_sel  = sync2[c];
    assign raw_code = CODE_W'(int'(r) * COLS + int'(c));
    assign key_held = (state == ST_HELD) || (state == ST_RELEASE);

`ifdef KEYPAD_HEX_MAP_EN
    generate
        if (ROWS == 4 && COLS == 4) begin : g_hex
            // Raw row-major code to printed legend of the lab keypad.
            always_comb begin
                case (raw_code)
                    4'd0:    mapped_code = 4'h1;
                    4'd1:    mapped_code = 4'h2;
                    4'd2:    mapped_code = 4'h3;
                    4'd3:    mapped_code = 4'hA;
                    4'd4:    mapped_code = 4'h4;
                    4'd5:    mapped_code = 4'h5;
                    4'd6:    mapped_code = 4'h6;
                    4'd7:    mapped_code = 4'hB;
                    4'd8:    mapped_code = 4'h7;
                    4'd9:    mapped_code = 4'h8;
                    4'd10:   mapped_code = 4'h9;
                    4'd11:   mapped_code = 4'hC;
                    4'd12:   mapped_code = 4'hE;
                    4'd13:   mapped_code = 4'h0;
                    4'd14:   mapped_code = 4'hF;
                    default: mapped_code = 4'hD;
                endcase
            end
        end else begin : g_raw
            $error("KEYPAD_HEX_MAP_EN needs a 4x4 keypad; using raw codes");
            assign mapped_code = raw_code;
        end
    endgenerate
`else
    assign mapped_code = raw_code;
`endif

    // Lowest-index low column of the synchronized sense lines.
    always_comb begin
        any_low = 1'b0;
        low_idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!sync2[i]) begin
                any_low = 1'b1;
                low_idx = CW'(i);
            end
        end
    end

    // One-hot active-low row drive from the row index.
    always_comb begin
        row_n    = '1;
        row_n[r] = 1'b0;
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_nx = state;
        dwell_nx = dwell;
        db_nx    = db_cnt;
        r_nx     = r;
        c_nx     = c;
        code_nx  = key_code;
        valid_nx = 1'b0;
        case (state)
            ST_SCAN: begin
                if (dwell != '0) begin
                    dwell_nx = dwell - 1'b1;
                end else if (any_low) begin
                    c_nx     = low_idx;
                    db_nx    = PRESS_LOAD;
                    state_nx = ST_PRESS;
                end else begin
                    r_nx     = r_inc;
                    dwell_nx = DWELL_LOAD;
                end
            end
            ST_PRESS: begin
                if (col_sel) begin
                    r_nx     = r_inc;
                    dwell_nx = DWELL_LOAD;
                    state_nx = ST_SCAN;
                end else if (db_cnt == '0) begin
                    code_nx  = mapped_code;
                    valid_nx = 1'b1;
                    state_nx = ST_HELD;
                end else begin
                    db_nx = db_cnt - 1'b1;
                end
            end
            ST_HELD: begin
                if (col_sel) begin
                    db_nx    = REL_LOAD;
                    state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!col_sel) begin
                    state_nx = ST_HELD;
                end else if (db_cnt == '0) begin
                    r_nx     = r_inc;
                    dwell_nx = DWELL_LOAD;
                    state_nx = ST_SCAN;
                end else begin
                    db_nx = db_cnt - 1'b1;
                end
            end
            default: begin
                state_nx = ST_SCAN;
            end
        endcase
    end

    // State, counters, synchronizer and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_SCAN;
            dwell     <= DWELL_LOAD;
            db_cnt    <= '0;
            r         <= '0;
            c         <= '0;
            sync1     <= '1;
            sync2     <= '1;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            dwell     <= dwell_nx;
            db_cnt    <= db_nx;
            r         <= r_nx;
            c         <= c_nx;
            sync1     <= col_n;
            sync2     <= sync1;
            key_code  <= code_nx;
            key_valid <= valid_nx;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner (4x4, SCAN_DIV=4,
// DEBOUNCE_CYCLES=8). Expected key codes are queued when a press is driven
// and popped when key_valid pulses.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0][3:0] pressed;
    int exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_push   = 0;
    logic prev_valid = 1'b0;
    logic [3:0] rot [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .col_n(col_n), .row_n(row_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a column reads low when a pressed key sits on a driven row.
    always_comb begin
        col_n = '1;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (!row_n[rr] && pressed[rr][cc]) col_n[cc] = 1'b0;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_code(input int r, input int c);
`ifdef KEYPAD_HEX_MAP_EN
        int legend [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
        return legend[r*4 + c];
`else
        return r*4 + c;
`endif
    endfunction

    task automatic expect_key(input int r, input int c);
        exp_q.push_back(exp_code(r, c));
        n_push++;
    endtask

    task automatic wait_held(input logic v, input int limit, output int n);
        n = 0;
        while (key_held !== v && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (key_held !== v) check("held_timeout", int'(key_held), int'(v));
    endtask

    // Leaves the bench on the first negedge at which row tgt is driven.
    task automatic wait_row_entry(input logic [3:0] tgt);
        int n;
        n = 0;
        while (row_n == tgt && n < 40) begin @(negedge clk); n++; end
        n = 0;
        while (row_n != tgt && n < 40) begin @(negedge clk); n++; end
        if (row_n != tgt) check("row_entry_timeout", int'(row_n), int'(tgt));
    endtask

    // Scoreboard: every key_valid pulse must match the oldest queued code.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", int'(key_valid), 0);
            end else begin
                check("key_code", int'(key_code), exp_q.pop_front());
            end
            check("held_with_valid", int'(key_held), 1);
            check("valid_one_cycle", int'(prev_valid), 0);
        end
        prev_valid = key_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] prev;
        reset   = 1'b0;
        pressed = '0;

        // Reset values and idle rotation.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_row_n", int'(row_n), 'hE);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        check("rst_code", int'(key_code), 0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            prev = row_n;
            n = 0;
            do begin @(negedge clk); n++; end while (row_n == prev && n < 20);
            check("rot_step_len", n, 4);
            check("rot_row", int'(row_n), int'(rot[i]));
        end

        // Clean press of (1,2).
        pressed[1][2] = 1'b1;
        expect_key(1, 2);
        wait_held(1'b1, 100, n);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("clean_row_frozen", int'(row_n), 'hD);
            check("clean_held", int'(key_held), 1);
        end
        pressed[1][2] = 1'b0;
        wait_held(1'b0, 40, n);
        check("release_latency", n, 10);
        check("row_after_release", int'(row_n), 'hB);
        check("code_kept", int'(key_code), exp_code(1, 2));

        // Bouncing (3,1), then held.
        for (int i = 0; i < 10; i++) begin
            pressed[3][1] = (i % 2 == 0);
            repeat (3) @(negedge clk);
        end
        pressed[3][1] = 1'b1;
        expect_key(3, 1);
        wait_held(1'b1, 200, n);
        repeat (5) @(negedge clk);
        pressed[3][1] = 1'b0;
        wait_held(1'b0, 40, n);

        // Two keys: (0,3) held, (2,0) pressed meanwhile.
        pressed[0][3] = 1'b1;
        expect_key(0, 3);
        wait_held(1'b1, 100, n);
        repeat (3) @(negedge clk);
        pressed[2][0] = 1'b1;
        repeat (20) @(negedge clk);
        check("first_key_still_held", int'(key_held), 1);
        check("first_key_code", int'(key_code), exp_code(0, 3));
        expect_key(2, 0);
        pressed[0][3] = 1'b0;
        wait_held(1'b0, 40, n);
        wait_held(1'b1, 100, n);
        check("second_key_code", int'(key_code), exp_code(2, 0));
        pressed[2][0] = 1'b0;
        wait_held(1'b0, 40, n);

        // Short glitch on (0,0): enters press debounce, rejected, row 1 next.
        wait_row_entry(4'b1110);
        pressed[0][0] = 1'b1;
        prev = row_n;
        n = 0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); n++; end
        pressed[0][0] = 1'b0;
        while (row_n == prev && n < 30) begin @(negedge clk); n++; end
        check("glitch_row_dwell", n, 8);
        check("glitch_next_row", int'(row_n), 'hD);
        check("glitch_held", int'(key_held), 0);

        // Reset four cycles into press debounce of (1,1).
        wait_row_entry(4'b1101);
        pressed[1][1] = 1'b1;
        repeat (8) @(negedge clk);
        check("press_db_frozen", int'(row_n), 'hD);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_row_n", int'(row_n), 'hE);
        check("mid_rst_valid", int'(key_valid), 0);
        check("mid_rst_held", int'(key_held), 0);
        check("mid_rst_code", int'(key_code), 0);
        pressed[1][1] = 1'b0;
        reset = 1'b1;
        repeat (30) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        check("valid_count", n_valid, n_push);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner: drives one keypad row low at a time and reads the active-low column lines. It debounces a press and emits the key code with a one-cycle valid strobe, then holds that key until a debounced release. It replaces the raw combinational row/column decode in the lab datapath. It sits between the keypad pins and the display/digit-shift logic, and is generalised to any ROWS×COLS matrix with configurable scan and debounce timing.

## Interface
- ROWS, 4, number of keypad rows (2..8)
- COLS, 4, number of keypad columns (2..8)
- SCAN_DIV, 1000, clock cycles each row is driven before moving to the next (≥4)
- DEBOUNCE_CYCLES, 20000, consecutive stable cycles required to accept a press or a release (≥2)
- CODE_W, $clog2(ROWS*COLS), key code width (derived; not overridden)
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- col_n  in  COLS  column sense lines, active-low (pulled up externally), asynchronous to clk
- row_n  out  ROWS  row drive, one-hot active-low
- key_code  out  CODE_W  code of the last accepted key
- key_valid  out  1  one-cycle pulse when a new key is accepted
- key_held  out  1  high while the accepted key remains pressed (until release debounced)

## Operation
- col_n passes through a 2-flop synchronizer before any use. All references below are to the synchronized value.
- Row index r and column index c are both 0-based. Raw code = r*COLS + c.
- FSM states:
  - SCAN
    - Drives row r. A dwell counter counts SCAN_DIV cycles.
    - On the last dwell cycle: if any synchronized column is low, latch r and the lowest-index low column c, then go to PRESS_DB. Otherwise r ← (r+1) mod ROWS.
  - PRESS_DB
    - Row r stays frozen. A counter counts the cycles in which column c is low.
    - If column c goes high before DEBOUNCE_CYCLES is reached: return to SCAN and advance r.
    - When the count reaches DEBOUNCE_CYCLES: load key_code, pulse key_valid, go to HELD.
  - HELD
    - Row r stays frozen and key_held = 1.
    - If column c goes high, go to RELEASE_DB.
  - RELEASE_DB
    - A counter counts the cycles in which column c is high.
    - If column c goes low again: return to HELD.
    - When the count reaches DEBOUNCE_CYCLES: key_held ← 0, go to SCAN, advance r.
- Multiple keys:
  - While in PRESS_DB, HELD or RELEASE_DB, only latched column c of row r is observed.
  - Other keys, in the same row or in other rows, are ignored. No key_valid is produced for them.
  - After release, a key that is still held elsewhere is found on a later scan and reported normally.
- key_code holds its value until the next accepted key. It does not clear on release.

## Timing
- Reset (reset=0 on a clk edge):
  - state = SCAN, r = 0, row_n = ~1 (row 0 low).
  - key_code = 0, key_valid = 0, key_held = 0.
  - All counters and both synchronizer stages are cleared to their idle values (synchronizer = all ones).
- Reset asserted mid-debounce or mid-hold aborts with no key_valid pulse.
- Row change: row_n updates on the clock edge that ends a dwell. The next row's first SCAN_DIV−1 cycles absorb the 2-cycle synchronizer lag, so samples are only taken on the last dwell cycle.
- Press latency: from the synchronized column going low in the sampled row to the key_valid pulse = DEBOUNCE_CYCLES cycles after entry to PRESS_DB. The pulse is exactly 1 cycle wide.
- key_code and key_held are valid in the same cycle as key_valid.
- key_held falls DEBOUNCE_CYCLES cycles after the synchronized column returns high with no bounce.
- Counter widths are sized from SCAN_DIV and DEBOUNCE_CYCLES. Counters saturate and never wrap.
- The row index wraps from ROWS−1 to 0.

## Configuration
- KEYPAD_HEX_MAP_EN
  - Defined, with ROWS=COLS=4: key_code is the legend value of the standard lab keypad.
    - Row 0: 1 2 3 A
    - Row 1: 4 5 6 B
    - Row 2: 7 8 9 C
    - Row 3: E 0 F D
  - Defined with any other geometry: raw code is used, and an elaboration-time $error is issued.
  - Not defined: key_code = raw code r*COLS + c.

## Test plan
The bench uses SCAN_DIV=4 and DEBOUNCE_CYCLES=8, with a keypad model where col_n[c] = 0 iff row_n[r] = 0 and key (r,c) is pressed.
- Reset: hold reset=0 for 3 cycles.
  - Required: row_n=4'b1110, key_valid=0, key_held=0, key_code=0.
  - With no key pressed, row_n then cycles 1110→1101→1011→0111→1110, one step every 4 cycles.
- Clean press of (1,2), i.e. "6":
  - With KEYPAD_HEX_MAP_EN, one key_valid pulse with key_code=4'h6. Without it, key_code=6.
  - key_held=1 until 8 cycles after release. row_n stays at 1101 throughout.
- Bounce: key (3,1) toggles every 3 cycles for 30 cycles, then is held.
  - Required: exactly one key_valid, with key_code=4'h0 (hex map) or 13 (raw).
  - No pulse is produced during the toggling.
- Short glitch: key (0,0) pressed for 5 cycles only.
  - Required: no key_valid. Scanning resumes at row 1.
- Two keys: hold (0,3), and while it is held, press (2,0).
  - Required: one pulse for 4'hA. Then, after (0,3) is released and debounced, one pulse for 4'h7.
- Reset mid-debounce: assert reset 4 cycles into PRESS_DB.
  - Required: no key_valid, and outputs return to their reset values.
